// File: rtl/cry_rom_arbiter_if.sv
// Bundle of requester handshakes and ROM-side signals for the CRY ROM arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cry_rom_arbiter_if;
  logic       req0;
  logic [7:0] addr0;
  logic       gnt0;
  logic       rvalid0;
  logic [7:0] rdata0;
  logic       req1;
  logic [7:0] addr1;
  logic       gnt1;
  logic       rvalid1;
  logic [7:0] rdata1;
  logic [0:7] rom_a;
  logic [0:7] rom_z;
  logic       busy;

  modport slave (
    input  req0, addr0, req1, addr1, rom_z,
    output gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_a, busy
  );

  modport master (
    output req0, addr0, req1, addr1, rom_z,
    input  gnt0, rvalid0, rdata0, gnt1, rvalid1, rdata1, rom_a, busy
  );
endinterface

// File: rtl/cry_rom_arbiter.sv
// Shares one registered 256x8 CRY lookup ROM between the video port (0, priority)
// and the CPU/blitter port (1), returning each result to its owner two cycles after acceptance.
module cry_rom_arbiter #(
  parameter int unsigned PRIO_BURST = 4
) (
  input logic               sys_clk,
  input logic               resetl,
  cry_rom_arbiter_if.slave  bus
);

  localparam logic [3:0] BURST_MAX = 4'(PRIO_BURST);

  logic [3:0] burstCnt_q, burstCnt_d;
  logic [7:0] lastAddr_q, lastAddr_d;
  logic       s1Valid_q, s1Port_q;
  logic       s2Valid_q, s2Port_q;
  logic [7:0] rdata0_q, rdata1_q;

  logic       burstFull;
  logic       gnt0, gnt1;
  logic [7:0] addrSel;
  logic [7:0] romData;
  logic [0:7] romA;

  // Port 1 wins a contended cycle only once port 0 has used up its burst allowance.
  always_comb begin
    burstFull = (burstCnt_q == BURST_MAX);
    gnt0      = bus.req0 & ~(bus.req1 & burstFull);
    gnt1      = bus.req1 & ~gnt0;

    addrSel = lastAddr_q;
    if (gnt0) begin
      addrSel = bus.addr0;
    end else if (gnt1) begin
      addrSel = bus.addr1;
    end
    lastAddr_d = addrSel;

    burstCnt_d = burstCnt_q;
    if (gnt1 || !bus.req1) begin
      burstCnt_d = 4'd0;
    end else if (gnt0 && !burstFull) begin
      burstCnt_d = burstCnt_q + 4'd1;
    end

    romA    = '0;
    romData = '0;
    for (int i = 0; i < 8; i++) begin
      romA[i]    = addrSel[i];
      romData[i] = bus.rom_z[i];
    end
  end

  // Reset forces the combinational outputs low as well as the registered ones.
  assign bus.gnt0    = gnt0 & resetl;
  assign bus.gnt1    = gnt1 & resetl;
  assign bus.rom_a   = resetl ? romA : '0;
  assign bus.rvalid0 = s2Valid_q & ~s2Port_q;
  assign bus.rvalid1 = s2Valid_q & s2Port_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.busy    = s1Valid_q | s2Valid_q;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      burstCnt_q <= '0;
      lastAddr_q <= '0;
      s1Valid_q  <= 1'b0;
      s1Port_q   <= 1'b0;
      s2Valid_q  <= 1'b0;
      s2Port_q   <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      burstCnt_q <= burstCnt_d;
      lastAddr_q <= lastAddr_d;
      s1Valid_q  <= gnt0 | gnt1;
      s1Port_q   <= gnt1;
      s2Valid_q  <= s1Valid_q;
      s2Port_q   <= s1Port_q;
      if (s1Valid_q && !s1Port_q) begin
        rdata0_q <= romData;
      end
      if (s1Valid_q && s1Port_q) begin
        rdata1_q <= romData;
      end
    end
  end

endmodule

// File: tb/tb_cry_rom_arbiter.sv
// Randomised bench for cry_rom_arbiter: a queue-based model of grants and returning
// lookups is compared against the DUT every cycle, plus a few literal pins.
module tb_cry_rom_arbiter;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic resetl;
  always #5 clk = ~clk;

  cry_rom_arbiter_if bus();

  cry_rom_arbiter #(.PRIO_BURST(PB)) dut (
    .sys_clk (clk),
    .resetl  (resetl),
    .bus     (bus)
  );

  logic [7:0] mem [256];

  function automatic int romIndex(input logic [0:7] a);
    int v;
    v = 0;
    for (int i = 0; i < 8; i++) begin
      if (a[i] === 1'b1) v += (1 << i);
    end
    return v;
  endfunction

  function automatic logic [0:7] toRom(input logic [7:0] d);
    logic [0:7] z;
    for (int i = 0; i < 8; i++) z[i] = d[i];
    return z;
  endfunction

  // Registered ROM: data for the address presented in a cycle appears the next cycle.
  always @(posedge clk) bus.rom_z <= toRom(mem[romIndex(bus.rom_a)]);

  typedef struct {
    int         port;
    logic [7:0] data;
    int         due;
  } res_t;

  res_t       pend[$];
  int         cyc;
  int         burst;
  logic [7:0] expRdata0, expRdata1, expRomA;
  int         checks, failures;
  logic       sampledGnt1;
  logic [9:0] seq;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic resetModel();
    pend.delete();
    burst     = 0;
    expRdata0 = '0;
    expRdata1 = '0;
    expRomA   = '0;
  endtask

  task automatic checkOutput(input bit g0, input bit g1);
    bit rv0, rv1, bsy;
    rv0 = 0; rv1 = 0; bsy = 0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc) begin
        if (pend[i].port == 0) begin rv0 = 1; expRdata0 = pend[i].data; end
        else                   begin rv1 = 1; expRdata1 = pend[i].data; end
      end
      if (pend[i].due == cyc || pend[i].due == cyc + 1) bsy = 1;
    end
    check("gnt0",    int'(bus.gnt0),     int'(g0));
    check("gnt1",    int'(bus.gnt1),     int'(g1));
    check("rom_a",   romIndex(bus.rom_a), int'(expRomA));
    check("rvalid0", int'(bus.rvalid0),  int'(rv0));
    check("rvalid1", int'(bus.rvalid1),  int'(rv1));
    check("rdata0",  int'(bus.rdata0),   int'(expRdata0));
    check("rdata1",  int'(bus.rdata1),   int'(expRdata1));
    check("busy",    int'(bus.busy),     int'(bsy));
    sampledGnt1 = bus.gnt1;
  endtask

  task automatic applyStimulus(input bit r0, input logic [7:0] a0,
                               input bit r1, input logic [7:0] a1);
    bit g0, g1;
    bus.req0  = r0;
    bus.addr0 = a0;
    bus.req1  = r1;
    bus.addr1 = a1;
    @(negedge clk);
    g0 = r0 && !(r1 && burst == PB);
    g1 = r1 && !g0;
    if (g0)      expRomA = a0;
    else if (g1) expRomA = a1;
    checkOutput(g0, g1);
    @(posedge clk);
    if (g0) pend.push_back('{0, mem[a0], cyc + 2});
    if (g1) pend.push_back('{1, mem[a1], cyc + 2});
    if (g1 || !r1)              burst = 0;
    else if (g0 && burst < PB)  burst++;
    cyc++;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 8'h00);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, "_gnt0"},    int'(bus.gnt0),    0);
    check({tag, "_gnt1"},    int'(bus.gnt1),    0);
    check({tag, "_rvalid0"}, int'(bus.rvalid0), 0);
    check({tag, "_rvalid1"}, int'(bus.rvalid1), 0);
    check({tag, "_rdata0"},  int'(bus.rdata0),  0);
    check({tag, "_rdata1"},  int'(bus.rdata1),  0);
    check({tag, "_rom_a"},   romIndex(bus.rom_a), 0);
    check({tag, "_busy"},    int'(bus.busy),    0);
  endtask

  // Reset asserted between clock edges, with whatever requests are currently driven.
  task automatic doReset();
    #2;
    resetl = 1'b0;
    #1;
    checkAllZero("midreset");
    resetModel();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetl = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    seq      = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[8'h10] = 8'hA5;
    bus.req0  = 1'b0;
    bus.addr0 = '0;
    bus.req1  = 1'b0;
    bus.addr1 = '0;
    resetl    = 1'b1;
    resetModel();

    #1 resetl = 1'b0;
    #1 checkAllZero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetl = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single port-0 lookup");
    applyStimulus(1, 8'h10, 0, 8'h00);
    idle(2);
    check("pin_rdata0_A5", int'(bus.rdata0), 8'hA5);
    check("pin_rdata1_zero", int'(bus.rdata1), 0);

    $display("[TB] burst limiter");
    idle(1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 8'($urandom_range(0, 255)), 1, 8'($urandom_range(0, 255)));
      seq[i] = sampledGnt1;
    end
    check("pin_burst_seq", int'(seq), 10'b10_0001_0000);
    idle(3);

    $display("[TB] port-1 sweep");
    for (int a = 0; a < 256; a++) applyStimulus(0, 8'h00, 1, 8'(a));
    idle(2);
    check("pin_rdata1_last", int'(bus.rdata1), int'(mem[255]));

    $display("[TB] interleaved 0,1,0");
    applyStimulus(1, 8'h20, 0, 8'h00);
    applyStimulus(0, 8'h00, 1, 8'h21);
    applyStimulus(1, 8'h22, 0, 8'h00);
    idle(3);

    $display("[TB] reset with lookups in flight");
    applyStimulus(1, 8'h33, 0, 8'h00);
    applyStimulus(1, 8'h44, 1, 8'h55);
    doReset();
    idle(4);

    $display("[TB] random traffic");
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)));
      if (i == 400) begin
        doReset();
      end
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
